// File: rtl/stack_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stack_ctrl_pkg
// Shared types and constants for the stack reverser controller and its users.
//   SYM_W       : width of one symbol on the streams and on the stack
//   SETTLE_CYC  : cycles the controller waits after a push/pop so that the
//                 stack's registered top/empty outputs have caught up
//   rev_state_t : controller FSM states
//   sym_t       : one symbol
// -----------------------------------------------------------------------------
package stack_ctrl_pkg;

  localparam int SYM_W      = 2;
  localparam int SETTLE_CYC = 2;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    F_WAIT = 2'd1,
    DRAIN  = 2'd2,
    D_WAIT = 2'd3
  } rev_state_t;

  typedef logic [SYM_W-1:0] sym_t;

endpackage

// File: rtl/stack_reverser_ctrl.sv
// -----------------------------------------------------------------------------
// stack_reverser_ctrl
// Accepts a burst of symbols on a valid/ready input stream, pushes each one onto
// an external 256 x 2-bit stack, then pops them and emits them in reverse order
// on a valid/ready output stream.
//
// Ports
//   clk, rst              : clock (rising edge), async active-high reset shared
//                           with the stack
//   in_valid/in_data/
//   in_last/in_ready      : producer stream; in_last closes the burst
//   out_valid/out_data/
//   out_last/out_ready    : consumer stream; out_last marks the final symbol
//   stk_push/stk_pop/
//   stk_din               : registered requests to the stack
//   stk_top/stk_empty     : stack outputs, valid two edges after a request
//   busy                  : low only when idle (FILL with nothing pushed)
//   overflow              : sticky, a burst was cut at MAX_DEPTH
//   err                   : sticky, stk_empty disagreed with the local count
// -----------------------------------------------------------------------------
module stack_reverser_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned MAX_DEPTH = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  sym_t in_data,
  input  logic in_last,
  output logic in_ready,
  output logic out_valid,
  output sym_t out_data,
  output logic out_last,
  input  logic out_ready,
  output logic stk_push,
  output logic stk_pop,
  output sym_t stk_din,
  input  sym_t stk_top,
  input  logic stk_empty,
  output logic busy,
  output logic overflow,
  output logic err
);

  localparam logic [CNT_W-1:0] MAX_CNT     = CNT_W'(MAX_DEPTH);
  localparam logic             SETTLE_LAST = 1'(SETTLE_CYC - 1);

  rev_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             settle_q, settle_d;
  logic             end_q, end_d;       // current burst is closed; F_WAIT goes to DRAIN
  logic             push_q, push_d;
  logic             pop_q, pop_d;
  sym_t             din_q, din_d;
  logic             overflow_q, overflow_d;
  logic             err_q, err_d;

  logic accept;
  logic settle_done;
  logic full_next;
  logic empty_mismatch;

  assign accept      = in_valid && (state_q == FILL);
  assign settle_done = (settle_q == SETTLE_LAST);
  assign full_next   = ((count_q + CNT_W'(1)) == MAX_CNT);

  // The count is authoritative; the stack's empty flag is only cross-checked
  // in states where its registered value has settled.
  assign empty_mismatch = ((state_q == FILL) && (count_q == '0) && !stk_empty) ||
                          ((state_q == DRAIN) && stk_empty);

  // NOTE: every signal gets a default at the top of always_comb so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    settle_d   = settle_q;
    end_d      = end_q;
    push_d     = 1'b0;
    pop_d      = 1'b0;
    din_d      = din_q;
    overflow_d = overflow_q;
    err_d      = err_q | empty_mismatch;

    unique case (state_q)
      FILL: begin
        if (accept) begin
          push_d   = 1'b1;
          din_d    = in_data;
          count_d  = count_q + CNT_W'(1);
          settle_d = 1'b0;
          state_d  = F_WAIT;
          end_d    = in_last || full_next;
          if (full_next && !in_last) overflow_d = 1'b1;
        end
      end
      F_WAIT: begin
        if (settle_done) begin
          state_d = end_q ? DRAIN : FILL;
          end_d   = 1'b0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          pop_d    = 1'b1;
          count_d  = count_q - CNT_W'(1);
          settle_d = 1'b0;
          state_d  = D_WAIT;
        end
      end
      D_WAIT: begin
        if (settle_done) begin
          state_d = (count_q != '0) ? DRAIN : FILL;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      count_q    <= '0;
      settle_q   <= 1'b0;
      end_q      <= 1'b0;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      din_q      <= '0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      settle_q   <= settle_d;
      end_q      <= end_d;
      push_q     <= push_d;
      pop_q      <= pop_d;
      din_q      <= din_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == DRAIN);
  assign out_data  = out_valid ? stk_top : '0;
  assign out_last  = out_valid && (count_q == CNT_W'(1));
  assign busy      = !((state_q == FILL) && (count_q == '0));
  assign stk_push  = push_q;
  assign stk_pop   = pop_q;
  assign stk_din   = din_q;
  assign overflow  = overflow_q;
  assign err       = err_q;

endmodule

// File: tb/tb_stack_reverser_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stack_reverser_ctrl
// Drives stack_reverser_ctrl paired with a behavioural 256 x 2-bit stack that
// shares clk/rst. A queue-based model turns every accepted burst into its
// reversed expected output list; one negedge process compares the DUT against
// it every cycle. Directed tests pin the model with literal expectations.
// -----------------------------------------------------------------------------
module tb_stack_reverser_ctrl;
  import stack_ctrl_pkg::*;

  localparam int MAX_DEPTH = 255;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_last, in_ready;
  sym_t in_data;
  logic out_valid, out_last, out_ready;
  sym_t out_data;
  logic stk_push, stk_pop;
  sym_t stk_din, stk_top;
  logic stk_empty_r, stk_empty_dut;
  logic busy, overflow, err;
  logic force_empty;

  always #5 clk = ~clk;

  stack_reverser_ctrl #(.MAX_DEPTH(MAX_DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .stk_push (stk_push),
    .stk_pop  (stk_pop),
    .stk_din  (stk_din),
    .stk_top  (stk_top),
    .stk_empty(stk_empty_dut),
    .busy     (busy),
    .overflow (overflow),
    .err      (err)
  );

  // ---------------- paired stack: top/empty registered from pointer state ----
  sym_t       mem [256];
  logic [8:0] sp_r;

  assign stk_empty_dut = force_empty ? 1'b1 : stk_empty_r;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_r        <= '0;
      stk_top     <= '0;
      stk_empty_r <= 1'b1;
    end else begin
      if (stk_push)     sp_r <= sp_r + 9'd1;
      else if (stk_pop) sp_r <= sp_r - 9'd1;
      stk_top     <= (sp_r == '0) ? 2'b00 : mem[8'(sp_r - 9'd1)];
      stk_empty_r <= (sp_r == '0);
    end
  end

  // NOTE: the stack memory is deliberately not reset; the pointer defines
  // which entries are meaningful.
  always @(posedge clk) begin
    if (!rst && stk_push) mem[sp_r[7:0]] <= stk_din;
  end

  // ---------------- checking infrastructure ---------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    sym_t data;
    logic last;
  } exp_t;

  sym_t  burst_q[$];
  exp_t  exp_q[$];
  exp_t  exp_e;
  sym_t  got_q[$];
  logic  m_overflow;
  logic  prev_accept, prev_hs, prev_stall;
  sym_t  prev_in, prev_out;
  int    pop_cnt;
  int    lat_cnt, lat_last;
  logic  lat_armed;
  logic  err_mode;
  int    ready_pct;

  // ---------------- per-cycle compare against the model --------------------
  always @(negedge clk) begin
    if (rst) begin
      burst_q.delete();
      exp_q.delete();
      m_overflow  = 1'b0;
      prev_accept = 1'b0;
      prev_hs     = 1'b0;
      prev_stall  = 1'b0;
      lat_armed   = 1'b0;
    end else begin
      check("stk_push_timing", stk_push, prev_accept);
      if (prev_accept) begin
        check("stk_din", stk_din, prev_in);
        check("in_ready_settle", in_ready, 1'b0);
      end
      check("stk_pop_timing", stk_pop, prev_hs);
      check("push_pop_excl", stk_push & stk_pop, 1'b0);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, prev_out);
      end
      if (exp_q.size() > 0) begin
        check("in_ready_drain", in_ready, 1'b0);
        check("busy_drain", busy, 1'b1);
      end
      if (burst_q.size() > 0) check("busy_fill", busy, 1'b1);
      if (out_valid) begin
        check("out_not_early", exp_q.size() != 0, 1'b1);
        check("out_data_top", out_data, stk_top);
      end
      check("overflow", overflow, m_overflow);
      if (!err_mode) check("err_clear", err, 1'b0);

      if (lat_armed) begin
        lat_cnt++;
        if (out_valid) begin
          lat_last  = lat_cnt;
          lat_armed = 1'b0;
        end
      end

      // record what happens at the upcoming edge
      prev_accept = in_valid && in_ready;
      prev_in     = in_data;
      prev_hs     = out_valid && out_ready;
      prev_stall  = out_valid && !out_ready;
      prev_out    = out_data;

      if (prev_accept) begin
        burst_q.push_back(in_data);
        if (in_last || burst_q.size() == MAX_DEPTH) begin
          if (!in_last) m_overflow = 1'b1;
          for (int i = burst_q.size() - 1; i >= 0; i--)
            exp_q.push_back(exp_t'{data: burst_q[i], last: (i == 0)});
          burst_q.delete();
          lat_armed = 1'b1;
          lat_cnt   = 0;
        end
      end

      if (prev_hs) begin
        check("out_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          check("out_data", out_data, exp_e.data);
          check("out_last", out_last, exp_e.last);
        end
        got_q.push_back(out_data);
        pop_cnt++;
      end
    end
  end

  // ---------------- consumer -----------------------------------------------
  always @(posedge clk) begin
    #1;
    out_ready = ($urandom_range(0, 99) < ready_pct);
  end

  // ---------------- driver tasks (start/end at posedge + 1) ----------------
  task automatic send(input sym_t d, input logic last, input int gap);
    int t;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready || t >= 5000) break;
      t++;
    end
    check("send_timeout", t < 5000, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || burst_q.size() != 0) && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    check("idle_timeout", t < 5000, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic wait_out_valid();
    int t;
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("out_valid_timeout", t < 100, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  in_ready,  1'b1);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_data"},  out_data,  2'b00);
    check({tag, "_out_last"},  out_last,  1'b0);
    check({tag, "_stk_push"},  stk_push,  1'b0);
    check({tag, "_stk_pop"},   stk_pop,   1'b0);
    check({tag, "_stk_din"},   stk_din,   2'b00);
    check({tag, "_busy"},      busy,      1'b0);
    check({tag, "_overflow"},  overflow,  1'b0);
    check({tag, "_err"},       err,       1'b0);
  endtask

  // ---------------- stimulus ------------------------------------------------
  sym_t sent_q[$];
  sym_t held;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b0; force_empty = 1'b0; err_mode = 1'b0;
    ready_pct = 100; pop_cnt = 0; lat_last = 0;
    repeat (3) begin @(posedge clk); #1; end
    check_reset_values("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // burst 1,2,3,0 -> 0,3,2,1
    got_q.delete(); pop_cnt = 0;
    send(2'd1, 1'b0, 0); send(2'd2, 1'b0, 0); send(2'd3, 1'b0, 0); send(2'd0, 1'b1, 0);
    wait_idle();
    check("t1_len", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check("t1_o0", got_q[0], 2'd0); check("t1_o1", got_q[1], 2'd3);
      check("t1_o2", got_q[2], 2'd2); check("t1_o3", got_q[3], 2'd1);
    end
    check("t1_pops", pop_cnt, 4);
    check("t1_latency", lat_last, 3);

    // single symbol burst
    got_q.delete();
    send(2'd2, 1'b1, 1);
    wait_idle();
    check("t2_len", got_q.size(), 1);
    if (got_q.size() == 1) check("t2_o0", got_q[0], 2'd2);
    check("t2_busy", busy, 1'b0);
    check("t2_in_ready", in_ready, 1'b1);

    // randomized bursts with random gaps and consumer backpressure
    for (int b = 0; b < 8; b++) begin
      int len;
      len = $urandom_range(1, 12);
      ready_pct = $urandom_range(30, 100);
      for (int k = 0; k < len; k++)
        send(sym_t'($urandom_range(0, 3)), k == len - 1, $urandom_range(0, 3));
      wait_idle();
    end
    ready_pct = 100;

    // consumer stalls 10 cycles in DRAIN
    ready_pct = 0;
    send(2'd3, 1'b0, 0); send(2'd1, 1'b0, 0); send(2'd2, 1'b1, 0);
    wait_out_valid();
    held = out_data;
    check("stall_first", held, 2'd2);
    repeat (10) begin
      @(posedge clk); #1;
      check("stall_valid", out_valid, 1'b1);
      check("stall_data", out_data, held);
      check("stall_nopop", stk_pop, 1'b0);
    end
    ready_pct = 100;
    wait_idle();

    // 255 symbols without last -> truncated burst, overflow
    got_q.delete(); sent_q.delete();
    for (int k = 0; k < MAX_DEPTH; k++) begin
      sym_t s;
      s = sym_t'($urandom_range(0, 3));
      sent_q.push_back(s);
      send(s, 1'b0, 0);
    end
    send(2'd1, 1'b1, 0);  // 256th symbol: held off until the drain completes
    wait_idle();
    check("ovf_flag", overflow, 1'b1);
    check("ovf_len", got_q.size(), MAX_DEPTH + 1);
    if (got_q.size() == MAX_DEPTH + 1) begin
      check("ovf_first", got_q[0], sent_q[MAX_DEPTH-1]);
      check("ovf_last", got_q[MAX_DEPTH-1], sent_q[0]);
      check("ovf_next", got_q[MAX_DEPTH], 2'd1);
    end

    // reset after three pushes
    send(2'd1, 1'b0, 0); send(2'd0, 1'b0, 0); send(2'd3, 1'b0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    got_q.delete();
    send(2'd3, 1'b0, 0); send(2'd1, 1'b1, 0);
    wait_idle();
    check("t5_len", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t5_o0", got_q[0], 2'd1);
      check("t5_o1", got_q[1], 2'd3);
    end
    check("t5_err", err, 1'b0);

    // stk_empty forced high during DRAIN -> sticky err
    ready_pct = 0;
    send(2'd2, 1'b0, 0); send(2'd1, 1'b1, 0);
    wait_out_valid();
    err_mode = 1'b1;
    check("force_pre_err", err, 1'b0);
    force_empty = 1'b1;
    @(posedge clk); #1;
    force_empty = 1'b0;
    check("force_err_set", err, 1'b1);
    ready_pct = 100;
    wait_idle();
    check("force_err_sticky", err, 1'b1);
    rst = 1'b1;
    #1;
    check("force_err_rst", err, 1'b0);
    err_mode = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
